fetch_sequencer: RTL and testbench

- Owns the program counter and sequences reads of the asynchronous program-memory ROM for the MIPS core.
- Registers the fetched word into an IF-stage output register with a valid flag.
- Handles stall and branch/jump redirect.
- Time-shares the single ROM read port with a debug/loader read requester, using bounded-wait arbitration.

---
 rtl/mips_fetch_pkg.sv | 12 +
 rtl/fetch_sequencer_if.sv | 36 +++
 rtl/fetch_dbg_arbiter.sv | 36 +++
 rtl/fetch_sequencer.sv | 117 +++++++++++
 tb/tb_fetch_sequencer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the MIPS fetch sequencer: FSM encoding, PC step and reset vector.
package mips_fetch_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        DBG   = 1'b1
    } fetch_state_e;

    localparam int          PC_INCR      = 4;
    localparam logic [31:0] PC_RESET_VEC = 32'h0040_0000;

endpackage

// File: rtl/fetch_sequencer_if.sv
// ROM read port and debug read requester bundle shared by the fetch sequencer and its environment.
interface fetch_sequencer_if #(
    parameter int DATA_WIDTH = 32
) ();

    // Debug handshake: the requester raises dbg_req_i with dbg_addr_i stable and holds both
    // until dbg_ack_o; the ack is a one-cycle pulse with dbg_data_o valid in that same cycle.
    // A request still high in the cycle after the ack is treated as a new request.
    logic                  dbg_req_i;
    logic [DATA_WIDTH-1:0] dbg_addr_i;
    logic                  dbg_ack_o;
    logic [DATA_WIDTH-1:0] dbg_data_o;

    // Asynchronous ROM: rom_instruction_i follows rom_address_o within the same cycle.
    logic [DATA_WIDTH-1:0] rom_address_o;
    logic [DATA_WIDTH-1:0] rom_instruction_i;

    modport slave (
        input  dbg_req_i,
        input  dbg_addr_i,
        input  rom_instruction_i,
        output dbg_ack_o,
        output dbg_data_o,
        output rom_address_o
    );

    modport master (
        output dbg_req_i,
        output dbg_addr_i,
        output rom_instruction_i,
        input  dbg_ack_o,
        input  dbg_data_o,
        input  rom_address_o
    );

endinterface

// File: rtl/fetch_dbg_arbiter.sv
// Bounded-wait arbiter deciding when a pending debug read may steal the ROM port from fetch.
module fetch_dbg_arbiter
    import mips_fetch_pkg::*;
#(
    parameter int DBG_WAIT_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic in_fetch,
    input  logic dbg_req,
    input  logic redirect,
    input  logic stall,
    input  logic instr_valid,
    output logic grant
);

    localparam logic [3:0] WAIT_MAX = 4'(DBG_WAIT_MAX);

    logic [3:0] wait_cnt;

    // Debug gets the port for free when fetch is idle (stalled or holding a bubble),
    // otherwise only after it has waited DBG_WAIT_MAX fetch cycles.
    assign grant = in_fetch && dbg_req && !redirect &&
                   (stall || (wait_cnt == WAIT_MAX) || !instr_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (!in_fetch || !dbg_req || grant) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// IF stage: PC, ROM sequencing, IF register, stall/redirect and debug read time-sharing.
// Optional misaligned-address fault flag is built when FETCH_ALIGN_CHECK_EN is defined.
module fetch_sequencer
    import mips_fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] PC_RESET     = DATA_WIDTH'(PC_RESET_VEC),
    parameter int                    DBG_WAIT_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_addr_i,
    fetch_sequencer_if.slave      bus,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] instr_pc_o,
    output logic                  instr_valid_o,
    output fetch_state_e          state_o
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic                  fetch_fault_o
`endif
);

    fetch_state_e          state_q, state_d;
    logic                  grant;
    logic                  dbg_ack_q;
    logic [DATA_WIDTH-1:0] dbg_data_q;
    logic [DATA_WIDTH-1:0] redirect_target;

    assign state_o           = state_q;
    assign bus.dbg_ack_o     = dbg_ack_q;
    assign bus.dbg_data_o    = dbg_data_q;
    assign bus.rom_address_o = (state_q == DBG) ? bus.dbg_addr_i : pc_o;

    fetch_dbg_arbiter #(
        .DBG_WAIT_MAX(DBG_WAIT_MAX)
    ) u_arbiter (
        .clk        (clk),
        .reset      (reset),
        .in_fetch   (state_q == FETCH),
        .dbg_req    (bus.dbg_req_i),
        .redirect   (redirect_i),
        .stall      (stall_i),
        .instr_valid(instr_valid_o),
        .grant      (grant)
    );

`ifdef FETCH_ALIGN_CHECK_EN
    assign redirect_target = {redirect_addr_i[DATA_WIDTH-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_fault_o <= 1'b0;
        end else if ((redirect_i && (redirect_addr_i[1:0] != 2'b00)) ||
                     (grant && (bus.dbg_addr_i[1:0] != 2'b00))) begin
            fetch_fault_o <= 1'b1;
        end
    end
`else
    assign redirect_target = redirect_addr_i;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_i) begin
            state_d = FETCH;
        end else if (state_q == DBG) begin
            state_d = FETCH;
        end else if (grant) begin
            state_d = DBG;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_o          <= PC_RESET;
            instr_o       <= '0;
            instr_pc_o    <= '0;
            instr_valid_o <= 1'b0;
            dbg_ack_q     <= 1'b0;
            dbg_data_q    <= '0;
        end else begin
            dbg_ack_q <= 1'b0;
            // A debug cycle always delivers its data, even if a redirect lands on the same edge.
            if (state_q == DBG) begin
                dbg_data_q <= bus.rom_instruction_i;
                dbg_ack_q  <= 1'b1;
            end

            if (redirect_i) begin
                pc_o          <= redirect_target;
                instr_valid_o <= 1'b0;
            end else if (state_q == DBG) begin
                if (!stall_i) begin
                    instr_valid_o <= 1'b0;
                end
            end else if (!stall_i && !grant) begin
                instr_o       <= bus.rom_instruction_i;
                instr_pc_o    <= pc_o;
                instr_valid_o <= 1'b1;
                pc_o          <= pc_o + DATA_WIDTH'(PC_INCR);
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: vector table for fetch/stall/redirect, hand sequences
// for debug arbitration; covers the fault flag when FETCH_ALIGN_CHECK_EN is defined.
module tb_fetch_sequencer;
    import mips_fetch_pkg::*;

    logic        clk;
    logic        reset;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_valid_o;
    fetch_state_e state_o;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_fault_o;
`endif

    int checks = 0;
    int errors = 0;

    fetch_sequencer_if #(.DATA_WIDTH(32)) bus ();

    fetch_sequencer #(
        .DATA_WIDTH  (32),
        .PC_RESET    (32'h0040_0000),
        .DBG_WAIT_MAX(4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall_i        (stall_i),
        .redirect_i     (redirect_i),
        .redirect_addr_i(redirect_addr_i),
        .bus            (bus),
        .pc_o           (pc_o),
        .instr_o        (instr_o),
        .instr_pc_o     (instr_pc_o),
        .instr_valid_o  (instr_valid_o),
        .state_o        (state_o)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fetch_fault_o  (fetch_fault_o)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: distinct, address-derived word per byte address.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
    endfunction

    assign bus.rom_instruction_i = rom_word(bus.rom_address_o);

    // ---------------- driver / checker tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        stall_i         = 1'b0;
        redirect_i      = 1'b0;
        redirect_addr_i = '0;
        bus.dbg_req_i   = 1'b0;
        bus.dbg_addr_i  = '0;
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] raddr;
        logic [31:0] e_pc;
        logic [31:0] e_ipc;
        logic        e_valid;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ipc;
        logic        valid;
    } exp_t;

    vec_t vecs[13];
    exp_t exp_q[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        logic seen;

        vecs[0]  = '{1'b0, 1'b0, 32'h0,         32'h0040_0004, 32'h0040_0000, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,         32'h0040_0008, 32'h0040_0004, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,         32'h0040_000C, 32'h0040_0008, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,         32'h0040_000C, 32'h0040_0008, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 32'h0040_0100, 32'h0040_0100, 32'h0040_0008, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,         32'h0040_0104, 32'h0040_0100, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 32'h0040_0200, 32'h0040_0200, 32'h0040_0100, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,         32'h0040_0200, 32'h0040_0100, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,         32'h0040_0204, 32'h0040_0200, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0040_0200, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 32'h0,         32'h0000_0000, 32'hFFFF_FFFC, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 32'h0,         32'h0000_0004, 32'h0000_0000, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 32'h0040_0000, 32'h0040_0000, 32'h0000_0000, 1'b0};

        // Reset state
        drive_idle();
        reset = 1'b1;
        step();
        step();
        check("rst_pc",      pc_o, 32'h0040_0000);
        check("rst_instr",   instr_o, 32'h0);
        check("rst_ipc",     instr_pc_o, 32'h0);
        check("rst_valid",   32'(instr_valid_o), 32'h0);
        check("rst_ack",     32'(bus.dbg_ack_o), 32'h0);
        check("rst_data",    bus.dbg_data_o, 32'h0);
        check("rst_state",   32'(state_o), 32'(FETCH));
        check("rst_romaddr", bus.rom_address_o, 32'h0040_0000);
        reset = 1'b0;

        // Table: free-run, stall, redirect, stall+redirect, wrap
        for (int i = 0; i < 13; i++) begin
            stall_i         = vecs[i].stall;
            redirect_i      = vecs[i].redirect;
            redirect_addr_i = vecs[i].raddr;
            exp_q.push_back('{pc: vecs[i].e_pc, ipc: vecs[i].e_ipc, valid: vecs[i].e_valid});
            step();
            e = exp_q.pop_front();
            check("tbl_pc",      pc_o, e.pc);
            check("tbl_ipc",     instr_pc_o, e.ipc);
            check("tbl_valid",   32'(instr_valid_o), 32'(e.valid));
            check("tbl_instr",   instr_o, rom_word(e.ipc));
            check("tbl_romaddr", bus.rom_address_o, e.pc);
        end
        drive_idle();

        // Debug request while fetch is busy: bounded wait of 4 cycles, then grant
        step();
        check("a_pre_ipc", instr_pc_o, 32'h0040_0000);
        bus.dbg_req_i  = 1'b1;
        bus.dbg_addr_i = 32'h0040_0020;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            step();
            n++;
            if (state_o == DBG) seen = 1'b1;
        end
        check("a_wait_edges", n, 5);
        check("a_dbg_pc",      pc_o, 32'h0040_0014);
        check("a_dbg_ipc",     instr_pc_o, 32'h0040_0010);
        check("a_dbg_romaddr", bus.rom_address_o, 32'h0040_0020);
        check("a_dbg_ack0",    32'(bus.dbg_ack_o), 32'h0);
        step();
        check("a_ack",   32'(bus.dbg_ack_o), 32'h1);
        check("a_data",  bus.dbg_data_o, rom_word(32'h0040_0020));
        check("a_valid", 32'(instr_valid_o), 32'h0);
        check("a_state", 32'(state_o), 32'(FETCH));
        bus.dbg_req_i = 1'b0;
        step();
        check("a_resume_ipc",   instr_pc_o, 32'h0040_0014);
        check("a_resume_instr", instr_o, rom_word(32'h0040_0014));
        check("a_resume_pc",    pc_o, 32'h0040_0018);
        check("a_ack_low",      32'(bus.dbg_ack_o), 32'h0);

        // Debug request with stall: immediate grant, instruction register untouched
        stall_i        = 1'b1;
        bus.dbg_req_i  = 1'b1;
        bus.dbg_addr_i = 32'h0040_0040;
        step();
        check("b_state", 32'(state_o), 32'(DBG));
        check("b_ack0",  32'(bus.dbg_ack_o), 32'h0);
        step();
        check("b_ack",   32'(bus.dbg_ack_o), 32'h1);
        check("b_data",  bus.dbg_data_o, rom_word(32'h0040_0040));
        check("b_instr", instr_o, rom_word(32'h0040_0014));
        check("b_valid", 32'(instr_valid_o), 32'h1);
        check("b_pc",    pc_o, 32'h0040_0018);
        drive_idle();
        step();
        check("b_ack_low", 32'(bus.dbg_ack_o), 32'h0);
        check("b_fetch",   instr_pc_o, 32'h0040_0018);

        // Debug request together with redirect: redirect first, grant on the flushed cycle
        bus.dbg_req_i   = 1'b1;
        bus.dbg_addr_i  = 32'h0040_0060;
        redirect_i      = 1'b1;
        redirect_addr_i = 32'h0040_0300;
        step();
        check("c_pc",    pc_o, 32'h0040_0300);
        check("c_valid", 32'(instr_valid_o), 32'h0);
        check("c_state", 32'(state_o), 32'(FETCH));
        check("c_ack0",  32'(bus.dbg_ack_o), 32'h0);
        redirect_i = 1'b0;
        step();
        check("c_grant", 32'(state_o), 32'(DBG));
        check("c_hold",  pc_o, 32'h0040_0300);
        step();
        check("c_ack",  32'(bus.dbg_ack_o), 32'h1);
        check("c_data", bus.dbg_data_o, rom_word(32'h0040_0060));
        bus.dbg_req_i = 1'b0;
        step();
        check("c_fetch_ipc",   instr_pc_o, 32'h0040_0300);
        check("c_fetch_valid", 32'(instr_valid_o), 32'h1);
        check("c_fetch_pc",    pc_o, 32'h0040_0304);

        // Redirect landing during the debug cycle: ack still delivered
        stall_i        = 1'b1;
        bus.dbg_req_i  = 1'b1;
        bus.dbg_addr_i = 32'h0040_0080;
        step();
        check("d_state", 32'(state_o), 32'(DBG));
        redirect_i      = 1'b1;
        redirect_addr_i = 32'h0040_0500;
        step();
        check("d_ack",   32'(bus.dbg_ack_o), 32'h1);
        check("d_data",  bus.dbg_data_o, rom_word(32'h0040_0080));
        check("d_pc",    pc_o, 32'h0040_0500);
        check("d_valid", 32'(instr_valid_o), 32'h0);
        drive_idle();
        step();
        check("d_ipc", instr_pc_o, 32'h0040_0500);

        // Reset during a debug cycle drops the ack
        stall_i        = 1'b1;
        bus.dbg_req_i  = 1'b1;
        bus.dbg_addr_i = 32'h0040_00A0;
        step();
        check("e_state", 32'(state_o), 32'(DBG));
        reset = 1'b1;
        step();
        check("e_ack",   32'(bus.dbg_ack_o), 32'h0);
        check("e_data",  bus.dbg_data_o, 32'h0);
        check("e_pc",    pc_o, 32'h0040_0000);
        check("e_state_rst", 32'(state_o), 32'(FETCH));
        reset = 1'b0;
        drive_idle();
        step();

`ifdef FETCH_ALIGN_CHECK_EN
        check("f_fault0", 32'(fetch_fault_o), 32'h0);
        redirect_i      = 1'b1;
        redirect_addr_i = 32'h0040_0102;
        step();
        drive_idle();
        check("f_pc",     pc_o, 32'h0040_0100);
        check("f_fault1", 32'(fetch_fault_o), 32'h1);
        step();
        step();
        check("f_sticky", 32'(fetch_fault_o), 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("f_fault_rst", 32'(fetch_fault_o), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
